// File: rtl/ifu_bpu_dyn.sv
// IFU branch prediction unit: a table of 2-bit counters for conditional branches
// (static BTFN, bimodal or gshare), static JAL/JALR target operands and JALR rs1 hazard wait.
module ifu_bpu_dyn #(
   parameter int PC_SIZE     = 32,
   parameter int XLEN        = 32,
   parameter int RFIDX_WIDTH = 5,
   parameter int BHT_IDXW    = 6,
   parameter int MODE        = 2,
   parameter int PERF_W      = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [PC_SIZE-1:0]     pc,
   input  logic                   dec_i_valid,
   input  logic                   dec_jal,
   input  logic                   dec_jalr,
   input  logic                   dec_bxx,
   input  logic [XLEN-1:0]        dec_bjp_imm,
   input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
   input  logic                   oitf_empty,
   input  logic                   ir_nop_instr,
   input  logic                   jalr_rs1idx_match_irrdidx,
   input  logic [XLEN-1:0]        rf2bpu_x1,
   input  logic [XLEN-1:0]        rf2bpu_rs1,
   input  logic                   upd_valid,
   input  logic [BHT_IDXW-1:0]    upd_idx,
   input  logic                   upd_taken,
   input  logic                   upd_mispred,
   output logic                   prdt_taken,
   output logic [BHT_IDXW-1:0]    prdt_idx,
   output logic [PC_SIZE-1:0]     prdt_pc_add_op1,
   output logic [PC_SIZE-1:0]     prdt_pc_add_op2,
   output logic                   bpu_wait,
   output logic [BHT_IDXW-1:0]    ghr,
   output logic [PERF_W-1:0]      mispred_cnt
);

   localparam int BHT_N = 1 << BHT_IDXW;

   logic [1:0]          bht_q [0:BHT_N-1];
   logic [1:0]          bht_d [0:BHT_N-1];
   logic [BHT_IDXW-1:0] ghr_q, ghr_d;
   logic [PERF_W-1:0]   mispred_cnt_q, mispred_cnt_d;

   logic [BHT_IDXW-1:0] pc_idx;
   logic                bxx_pred;
   logic                rs1_x0, rs1_x1;
   logic                wait_x1, wait_xn;
   logic                unused_bits;

   assign unused_bits = ^{pc, dec_bjp_imm, rf2bpu_x1, rf2bpu_rs1};

   assign pc_idx   = pc[BHT_IDXW+1:2];
   assign prdt_idx = (MODE == 2) ? (pc_idx ^ ghr_q) : pc_idx;

   // Prediction reads the registered table, so a same-cycle update is not visible yet.
   assign bxx_pred   = (MODE == 0) ? dec_bjp_imm[XLEN-1] : bht_q[prdt_idx][1];
   assign prdt_taken = dec_jal | dec_jalr | (dec_bxx & bxx_pred);

   assign rs1_x0 = (dec_jalr_rs1idx == RFIDX_WIDTH'(0));
   assign rs1_x1 = (dec_jalr_rs1idx == RFIDX_WIDTH'(1));

   always_comb begin
      prdt_pc_add_op1 = PC_SIZE'(rf2bpu_rs1);
      if (dec_bxx | dec_jal) begin
         prdt_pc_add_op1 = pc;
      end else if (rs1_x0) begin
         prdt_pc_add_op1 = '0;
      end else if (rs1_x1) begin
         prdt_pc_add_op1 = PC_SIZE'(rf2bpu_x1);
      end
   end

   assign prdt_pc_add_op2 = PC_SIZE'(dec_bjp_imm);

   // x1 is forwarded from the regfile directly, so only an in-flight writer of x1 blocks it.
   assign wait_x1  = dec_i_valid & dec_jalr & rs1_x1 & (~oitf_empty | jalr_rs1idx_match_irrdidx);
   assign wait_xn  = dec_i_valid & dec_jalr & ~rs1_x0 & ~rs1_x1 & (~oitf_empty | ~ir_nop_instr);
   assign bpu_wait = wait_x1 | wait_xn;

   always_comb begin
      bht_d         = bht_q;
      ghr_d         = ghr_q;
      mispred_cnt_d = mispred_cnt_q;
      if (upd_valid) begin
         if (upd_taken) begin
            if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
         end else begin
            if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
         end
         ghr_d = {ghr_q[BHT_IDXW-2:0], upd_taken};
         if (upd_mispred && (mispred_cnt_q != '1)) begin
            mispred_cnt_d = mispred_cnt_q + PERF_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
         ghr_q         <= '0;
         mispred_cnt_q <= '0;
      end else begin
         bht_q         <= bht_d;
         ghr_q         <= ghr_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign ghr         = ghr_q;
   assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_ifu_bpu_dyn.sv
// Directed and randomised checks of ifu_bpu_dyn in bimodal, gshare and static modes,
// plus a narrow mispredict counter instance.
module tb_ifu_bpu_dyn;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc;
   logic        dec_i_valid, dec_jal, dec_jalr, dec_bxx;
   logic [31:0] imm;
   logic [4:0]  rs1idx;
   logic        oitf_empty, ir_nop, rd_match;
   logic [31:0] x1_val, rs1_val;
   logic [3:0]  upd_valid;
   logic [5:0]  upd_idx;
   logic        upd_taken, upd_mispred;

   logic        tk_b, tk_g, tk_s, tk_p;
   logic [5:0]  idx_b, idx_g, idx_s, idx_p;
   logic [31:0] op1_b, op1_g, op1_s, op1_p;
   logic [31:0] op2_b, op2_g, op2_s, op2_p;
   logic        wait_b, wait_g, wait_s, wait_p;
   logic [5:0]  ghr_b, ghr_g, ghr_s, ghr_p;
   logic [31:0] cnt_b, cnt_g, cnt_s;
   logic [1:0]  cnt_p;

   logic [31:0] exp_q[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          m_bht[64];
   int          m_ghr, m_cnt;

   always #5 clk = ~clk;

   ifu_bpu_dyn #(.MODE(1)) u_bim (
      .clk(clk), .rst(rst), .pc(pc), .dec_i_valid(dec_i_valid), .dec_jal(dec_jal),
      .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_bjp_imm(imm), .dec_jalr_rs1idx(rs1idx),
      .oitf_empty(oitf_empty), .ir_nop_instr(ir_nop), .jalr_rs1idx_match_irrdidx(rd_match),
      .rf2bpu_x1(x1_val), .rf2bpu_rs1(rs1_val), .upd_valid(upd_valid[0]), .upd_idx(upd_idx),
      .upd_taken(upd_taken), .upd_mispred(upd_mispred), .prdt_taken(tk_b), .prdt_idx(idx_b),
      .prdt_pc_add_op1(op1_b), .prdt_pc_add_op2(op2_b), .bpu_wait(wait_b), .ghr(ghr_b),
      .mispred_cnt(cnt_b));

   ifu_bpu_dyn #(.MODE(2)) u_gsh (
      .clk(clk), .rst(rst), .pc(pc), .dec_i_valid(dec_i_valid), .dec_jal(dec_jal),
      .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_bjp_imm(imm), .dec_jalr_rs1idx(rs1idx),
      .oitf_empty(oitf_empty), .ir_nop_instr(ir_nop), .jalr_rs1idx_match_irrdidx(rd_match),
      .rf2bpu_x1(x1_val), .rf2bpu_rs1(rs1_val), .upd_valid(upd_valid[1]), .upd_idx(upd_idx),
      .upd_taken(upd_taken), .upd_mispred(upd_mispred), .prdt_taken(tk_g), .prdt_idx(idx_g),
      .prdt_pc_add_op1(op1_g), .prdt_pc_add_op2(op2_g), .bpu_wait(wait_g), .ghr(ghr_g),
      .mispred_cnt(cnt_g));

   ifu_bpu_dyn #(.MODE(0)) u_sta (
      .clk(clk), .rst(rst), .pc(pc), .dec_i_valid(dec_i_valid), .dec_jal(dec_jal),
      .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_bjp_imm(imm), .dec_jalr_rs1idx(rs1idx),
      .oitf_empty(oitf_empty), .ir_nop_instr(ir_nop), .jalr_rs1idx_match_irrdidx(rd_match),
      .rf2bpu_x1(x1_val), .rf2bpu_rs1(rs1_val), .upd_valid(upd_valid[2]), .upd_idx(upd_idx),
      .upd_taken(upd_taken), .upd_mispred(upd_mispred), .prdt_taken(tk_s), .prdt_idx(idx_s),
      .prdt_pc_add_op1(op1_s), .prdt_pc_add_op2(op2_s), .bpu_wait(wait_s), .ghr(ghr_s),
      .mispred_cnt(cnt_s));

   ifu_bpu_dyn #(.MODE(1), .PERF_W(2)) u_perf (
      .clk(clk), .rst(rst), .pc(pc), .dec_i_valid(dec_i_valid), .dec_jal(dec_jal),
      .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_bjp_imm(imm), .dec_jalr_rs1idx(rs1idx),
      .oitf_empty(oitf_empty), .ir_nop_instr(ir_nop), .jalr_rs1idx_match_irrdidx(rd_match),
      .rf2bpu_x1(x1_val), .rf2bpu_rs1(rs1_val), .upd_valid(upd_valid[3]), .upd_idx(upd_idx),
      .upd_taken(upd_taken), .upd_mispred(upd_mispred), .prdt_taken(tk_p), .prdt_idx(idx_p),
      .prdt_pc_add_op1(op1_p), .prdt_pc_add_op2(op2_p), .bpu_wait(wait_p), .ghr(ghr_p),
      .mispred_cnt(cnt_p));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic push_exp(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: observed %0h, no expected value queued", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
         end
      end
   endtask

   task automatic do_upd(input logic [3:0] which, input logic t, input logic mis,
                         input logic [5:0] i);
      upd_valid   = which;
      upd_taken   = t;
      upd_mispred = mis;
      upd_idx     = i;
      tick();
      upd_valid   = '0;
      upd_mispred = 1'b0;
   endtask

   task automatic upd_chk_b(input logic t, input logic e, input string tag);
      do_upd(4'b0001, t, 1'b0, 6'd0);
      push_exp(32'(e));
      settle();
      chk(tag, 32'(tk_b));
   endtask

   initial begin
      rst = 1'b1;
      pc = 32'h100; dec_i_valid = 1'b1; dec_jal = 1'b0; dec_jalr = 1'b0; dec_bxx = 1'b1;
      imm = -32'sd8; rs1idx = 5'd0; oitf_empty = 1'b1; ir_nop = 1'b1; rd_match = 1'b0;
      x1_val = 32'h1111_0000; rs1_val = 32'h2222_0000;
      upd_valid = '0; upd_idx = '0; upd_taken = 1'b0; upd_mispred = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // reset state
      push_exp(32'd0); push_exp(32'd0); push_exp(32'd0); push_exp(32'd0);
      push_exp(32'h100); push_exp(32'hFFFF_FFF8); push_exp(32'd0);
      settle();
      chk("rst_tk_b", 32'(tk_b));
      chk("rst_idx_b", 32'(idx_b));
      chk("rst_ghr_g", 32'(ghr_g));
      chk("rst_cnt_g", cnt_g);
      chk("rst_op1_b", op1_b);
      chk("rst_op2_b", op2_b);
      chk("rst_idx_g", 32'(idx_g));

      // bimodal: read-before-write, then saturation at both ends
      tick();
      upd_valid = 4'b0001; upd_taken = 1'b1; upd_idx = 6'd0;
      push_exp(32'd0);
      settle();
      chk("b_rbw", 32'(tk_b));
      tick();
      upd_valid = '0;
      push_exp(32'd1); settle(); chk("b_t1", 32'(tk_b));
      upd_chk_b(1'b1, 1'b1, "b_t2");
      upd_chk_b(1'b1, 1'b1, "b_t3_sat");
      upd_chk_b(1'b0, 1'b1, "b_n1");
      upd_chk_b(1'b0, 1'b0, "b_n2");
      upd_chk_b(1'b0, 1'b0, "b_n3");
      upd_chk_b(1'b0, 1'b0, "b_n4_sat");
      upd_chk_b(1'b1, 1'b0, "b_t4");
      upd_chk_b(1'b1, 1'b1, "b_t5");
      pc = 32'h104;
      push_exp(32'd1); push_exp(32'd0); push_exp(32'd3); push_exp(32'd0);
      settle();
      chk("b_other_idx", 32'(idx_b));
      chk("b_other_tk", 32'(tk_b));
      chk("b_ghr", 32'(ghr_b));
      chk("b_cnt", cnt_b);

      // gshare: history shifts in at resolution and is xored into the index
      pc = 32'h100;
      do_upd(4'b0010, 1'b1, 1'b0, 6'd0);
      push_exp(32'd1); settle(); chk("g_ghr1", 32'(ghr_g));
      do_upd(4'b0010, 1'b1, 1'b0, 6'd0);
      push_exp(32'd3); settle(); chk("g_ghr2", 32'(ghr_g));
      do_upd(4'b0010, 1'b0, 1'b0, 6'd0);
      push_exp(32'd6); push_exp(32'd6); push_exp(32'd0);
      settle();
      chk("g_ghr3", 32'(ghr_g));
      chk("g_idx_100", 32'(idx_g));
      chk("g_tk_100", 32'(tk_g));
      pc = 32'h118;
      push_exp(32'd0); push_exp(32'd1);
      settle();
      chk("g_idx_118", 32'(idx_g));
      chk("g_tk_118", 32'(tk_g));

      // static: sign of the immediate decides, table contents ignored
      pc = 32'h100;
      do_upd(4'b0100, 1'b1, 1'b0, 6'd0);
      do_upd(4'b0100, 1'b1, 1'b0, 6'd0);
      imm = -32'sd4;
      push_exp(32'd1); settle(); chk("s_back", 32'(tk_s));
      imm = 32'd16;
      push_exp(32'd0); push_exp(32'd16); push_exp(32'd1);
      settle();
      chk("s_fwd", 32'(tk_s));
      chk("s_op2", op2_s);
      chk("b_fwd_tbl", 32'(tk_b));
      pc = 32'h104; imm = -32'sd4;
      push_exp(32'd0); settle(); chk("b_back_tbl", 32'(tk_b));
      pc = 32'h100; dec_bxx = 1'b0; dec_jal = 1'b1; imm = 32'd16;
      push_exp(32'd1); push_exp(32'h100);
      settle();
      chk("s_jal_tk", 32'(tk_s));
      chk("s_jal_op1", op1_s);

      // JALR dependency wait and operand selection
      dec_jal = 1'b0; dec_jalr = 1'b1; rs1idx = 5'd5; oitf_empty = 1'b1; ir_nop = 1'b0;
      imm = 32'd8;
      push_exp(32'd1); push_exp(32'd1);
      settle();
      chk("w_xn_ir", 32'(wait_b));
      chk("jalr_tk", 32'(tk_b));
      ir_nop = 1'b1;
      push_exp(32'd0); push_exp(32'h2222_0000); push_exp(32'd8);
      settle();
      chk("w_xn_free", 32'(wait_b));
      chk("op1_rs1", op1_b);
      chk("op2_jalr", op2_b);
      oitf_empty = 1'b0;
      push_exp(32'd1); settle(); chk("w_xn_oitf", 32'(wait_b));
      rs1idx = 5'd0;
      push_exp(32'd0); push_exp(32'd0);
      settle();
      chk("w_x0", 32'(wait_b));
      chk("op1_x0", op1_b);
      rs1idx = 5'd1; oitf_empty = 1'b1; ir_nop = 1'b0; rd_match = 1'b0;
      push_exp(32'd0); push_exp(32'h1111_0000);
      settle();
      chk("w_x1_free", 32'(wait_b));
      chk("op1_x1", op1_b);
      rd_match = 1'b1;
      push_exp(32'd1); settle(); chk("w_x1_match", 32'(wait_b));
      rd_match = 1'b0; oitf_empty = 1'b0;
      push_exp(32'd1); settle(); chk("w_x1_oitf", 32'(wait_b));
      dec_i_valid = 1'b0;
      push_exp(32'd0); settle(); chk("w_invalid", 32'(wait_b));
      dec_i_valid = 1'b1; dec_jalr = 1'b0;
      push_exp(32'd0); push_exp(32'd0);
      settle();
      chk("noflag_tk", 32'(tk_b));
      chk("noflag_wait", 32'(wait_b));
      oitf_empty = 1'b1; ir_nop = 1'b1; rs1idx = 5'd0; dec_bxx = 1'b1;

      // narrow mispredict counter
      upd_mispred = 1'b1;
      tick();
      upd_mispred = 1'b0;
      push_exp(32'd0); settle(); chk("p_mis_novalid", 32'(cnt_p));
      do_upd(4'b1000, 1'b1, 1'b1, 6'd5);
      push_exp(32'd1); settle(); chk("p_cnt1", 32'(cnt_p));
      do_upd(4'b1000, 1'b1, 1'b1, 6'd5);
      push_exp(32'd2); settle(); chk("p_cnt2", 32'(cnt_p));
      do_upd(4'b1000, 1'b1, 1'b1, 6'd5);
      push_exp(32'd3); settle(); chk("p_cnt3", 32'(cnt_p));
      do_upd(4'b1000, 1'b1, 1'b1, 6'd5);
      push_exp(32'd3); settle(); chk("p_cnt_sat", 32'(cnt_p));

      // reset wins over a coincident update
      pc = 32'h100; imm = -32'sd8;
      rst = 1'b1;
      do_upd(4'b1111, 1'b1, 1'b1, 6'd0);
      rst = 1'b0;
      tick();
      push_exp(32'd0); push_exp(32'd0); push_exp(32'd0); push_exp(32'd0);
      push_exp(32'd0); push_exp(32'd0);
      settle();
      chk("r_cnt_p", 32'(cnt_p));
      chk("r_ghr_p", 32'(ghr_p));
      chk("r_tk_p", 32'(tk_p));
      chk("r_tk_b", 32'(tk_b));
      chk("r_ghr_g", 32'(ghr_g));
      chk("r_cnt_g", cnt_g);

      // random updates against a counter-table model
      for (int i = 0; i < 64; i++) m_bht[i] = 1;
      m_ghr = 0;
      m_cnt = 0;
      for (int n = 0; n < 48; n++) begin
         int pidx, uidx;
         logic v, t, mis;
         pidx = $urandom_range(0, 63);
         uidx = (n % 4 == 0) ? pidx : $urandom_range(0, 63);
         v    = 1'($urandom_range(0, 3) != 0);
         t    = 1'($urandom_range(0, 1));
         mis  = 1'($urandom_range(0, 1));
         pc = 32'(pidx) << 2;
         upd_valid = {v, 3'b000};
         upd_idx = 6'(uidx); upd_taken = t; upd_mispred = mis;
         push_exp(32'(pidx)); push_exp(32'(m_bht[pidx] >= 2));
         settle();
         chk("rnd_idx", 32'(idx_p));
         chk("rnd_tk", 32'(tk_p));
         tick();
         if (v) begin
            if (t) begin
               if (m_bht[uidx] != 3) m_bht[uidx]++;
            end else if (m_bht[uidx] != 0) begin
               m_bht[uidx]--;
            end
            m_ghr = ((m_ghr << 1) | int'(t)) & 63;
            if (mis && m_cnt != 3) m_cnt++;
         end
      end
      upd_valid = '0; upd_mispred = 1'b0;
      push_exp(32'(m_ghr)); push_exp(32'(m_cnt));
      settle();
      chk("rnd_ghr", 32'(ghr_p));
      chk("rnd_cnt", 32'(cnt_p));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ifu_bpu_dyn.md
Name: ifu_bpu_dyn

Overview:
Parametrised second-generation IFU branch prediction unit. It replaces pure BTFN static prediction for conditional branches with a table of 2-bit saturating counters, selectable by MODE: static BTFN, bimodal, or gshare. Static JAL/JALR handling and JALR rs1 dependency stalling are retained. The block sits between ifu_minidec and the IFU next-PC adder, and receives resolution updates from the EXU branch unit.

Parameters:
PC_SIZE, 32, PC width
XLEN, 32, data/immediate width
RFIDX_WIDTH, 5, register index width
BHT_IDXW, 6, log2 of BHT entries (64 entries); legal range 2..12
MODE, 2, 0 = static BTFN, 1 = bimodal (PC-indexed), 2 = gshare (PC xor GHR)
PERF_W, 32, mispredict counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
pc  in  PC_SIZE  PC of decoded instruction
dec_i_valid  in  1  decoded instruction valid
dec_jal / dec_jalr / dec_bxx  in  1 each  minidecode type flags (at most one set)
dec_bjp_imm  in  XLEN  sign-extended B/J immediate
dec_jalr_rs1idx  in  RFIDX_WIDTH  JALR rs1 index
oitf_empty  in  1  no outstanding long instructions
ir_nop_instr  in  1  IR holds no instruction
jalr_rs1idx_match_irrdidx  in  1  IR rd equals JALR rs1
rf2bpu_x1 / rf2bpu_rs1  in  XLEN each  regfile x1 / read-port-1 value
upd_valid  in  1  EXU resolved a conditional branch this cycle
upd_idx  in  BHT_IDXW  prdt_idx captured at prediction time
upd_taken  in  1  actual outcome
upd_mispred  in  1  prediction was wrong
prdt_taken  out  1  predicted taken
prdt_idx  out  BHT_IDXW  table index used for this prediction
prdt_pc_add_op1 / prdt_pc_add_op2  out  PC_SIZE each  next-PC adder operands
bpu_wait  out  1  hold IFU for JALR dependency
ghr  out  BHT_IDXW  global history register (debug)
mispred_cnt  out  PERF_W  saturating mispredict count

Behaviour:
- Reset (rst=1 at an edge): all BHT counters = 2'b01 (weakly not-taken); ghr = 0; mispred_cnt = 0. Combinational outputs follow the inputs with reset state applied. rst takes priority over a simultaneous upd_valid, which is dropped.
- Index: MODE 1: idx = pc[BHT_IDXW+1:2]. MODE 2: idx = pc[BHT_IDXW+1:2] ^ ghr. MODE 0: idx = pc[BHT_IDXW+1:2]; the table is still updated but is not used for prediction. prdt_idx = idx, combinational.
- prdt_taken = dec_jal | dec_jalr | (dec_bxx & bxx_pred). bxx_pred = dec_bjp_imm[XLEN-1] in MODE 0, else BHT[idx][1]. Prediction is a zero-latency combinational read of the registered table.
- Update on upd_valid (counter sequence 00 -> 01 -> 10 -> 11): taken increments, saturating at 11; not-taken decrements, saturating at 00. Takes effect next cycle.
- Same-cycle read and update of the same index: the prediction sees the pre-update value (read-before-write).
- GHR: on upd_valid, ghr <= {ghr[BHT_IDXW-2:0], upd_taken}. Updated at resolution only, never speculatively.
- mispred_cnt increments on upd_valid & upd_mispred and saturates at all-ones. upd_mispred without upd_valid is ignored.
- Adder operands: op1 = pc for dec_bxx|dec_jal; 0 for JALR with rs1=x0; rf2bpu_x1 for JALR with rs1=x1; otherwise rf2bpu_rs1. op2 = dec_bjp_imm[PC_SIZE-1:0].
- Wait logic:
  - x1 dependency = dec_i_valid & dec_jalr & rs1==1 & (~oitf_empty | jalr_rs1idx_match_irrdidx).
  - xN dependency = dec_i_valid & dec_jalr & rs1∉{0,1} & (~oitf_empty | ~ir_nop_instr).
  - bpu_wait = x1 dependency | xN dependency. bpu_wait has no effect on table state.
- With no type flag set, prdt_taken = 0; outputs are don't-care except prdt_taken and bpu_wait.

Test Plan:
- Reset, MODE=1, pc=0x100, dec_bxx=1, imm=-8 -> prdt_taken=0 (counter 01), prdt_idx=0; ghr=0, mispred_cnt=0.
- MODE=1, two upd_valid taken to idx 0 -> counter 11, prdt_taken=1 for pc=0x100; a third taken keeps 11; three not-taken -> 00, prdt_taken=0.
- MODE=2, three updates taken,taken,not-taken -> ghr=6'b000110; pc=0x100 -> prdt_idx=6.
- MODE=0, dec_bxx with imm=-4 -> taken; imm=+16 -> not taken, independent of table contents.
- JALR rs1=x5, ir_nop_instr=0 -> bpu_wait=1; ir_nop_instr=1 with oitf_empty=1 -> bpu_wait=0 and op1=rf2bpu_rs1. JALR rs1=x0 -> op1=0.
- PERF_W=2, four upd_valid&upd_mispred -> mispred_cnt=3 (saturated); rst mid-stream clears it to 0 and drops a coincident update.
